// File: rtl/tdm_demux1to4_pkg.sv
// Shared slot and state constants for the TDM link. The transmit-side 4:1 mux
// uses the same slot numbering, so both ends agree on which slot carries which channel.
package tdm_demux1to4_pkg;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } tdm_state_e;

    function automatic logic [3:0] slot_onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter and HUNT/LOCK framing FSM. Decides which beat is stored where,
// when a frame completes, and when framing is violated.
module tdm_slot_ctr
    import tdm_demux1to4_pkg::*;
#(
    parameter bit REQUIRE_SOF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_valid,
    input  logic       din_sof,
    output logic [1:0] slot,
    output logic       locked,
    output logic       sync_err,
    output logic       wr_en,
    output logic [1:0] wr_slot,
    output logic       publish
);

    localparam tdm_state_e RST_ST = REQUIRE_SOF ? ST_HUNT : ST_LOCK;

    tdm_state_e state;
    logic       sof;
    logic       err;
    logic       miss;

    // With free-running framing the marker is meaningless and must not perturb slotting.
    assign sof    = REQUIRE_SOF && din_sof;
    assign locked = (state == ST_LOCK);

    always_comb begin
        wr_en   = 1'b0;
        wr_slot = SLOT_A;
        err     = 1'b0;
        miss    = 1'b0;
        if (din_valid) begin
            if (state == ST_HUNT) begin
                wr_en = sof;
            end else if (sof) begin
                wr_en = 1'b1;
                err   = (slot != SLOT_A);
            end else if (REQUIRE_SOF && slot == SLOT_A) begin
                miss = 1'b1;
                err  = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_slot = slot;
            end
        end
    end

    assign publish = wr_en && (wr_slot == SLOT_D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST_ST;
            slot     <= SLOT_A;
            sync_err <= 1'b0;
        end else begin
            sync_err <= err;
            if (miss) begin
                state <= ST_HUNT;
                slot  <= SLOT_A;
            end else if (wr_en) begin
                state <= ST_LOCK;
                slot  <= wr_slot + 2'd1;
            end
        end
    end

endmodule

// File: rtl/tdm_demux1to4.sv
// Receive end of a 4:1 TDM lane: stages one frame in shadow registers and
// publishes A..D together when the slot-D beat is accepted.
module tdm_demux1to4
    import tdm_demux1to4_pkg::*;
#(
    parameter int W           = 1,
    parameter bit REQUIRE_SOF = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         din_sof,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic         frame_valid,
    output logic [1:0]   slot,
    output logic         locked,
    output logic         sync_err
);

    logic       wr_en;
    logic [1:0] wr_slot;
    logic       publish;
    logic [3:0] wr_sel;
    logic [W-1:0] sh [3];

    tdm_slot_ctr #(.REQUIRE_SOF(REQUIRE_SOF)) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din_sof   (din_sof),
        .slot      (slot),
        .locked    (locked),
        .sync_err  (sync_err),
        .wr_en     (wr_en),
        .wr_slot   (wr_slot),
        .publish   (publish)
    );

    assign wr_sel = wr_en ? slot_onehot(wr_slot) : 4'b0000;

    // Slot D needs no shadow: it is the beat that completes the frame and goes straight out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) sh[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (wr_sel[i]) sh[i] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a           <= '0;
            b           <= '0;
            c           <= '0;
            d           <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= publish;
            if (publish) begin
                a <= sh[0];
                b <= sh[1];
                c <= sh[2];
                d <= din;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux1to4.sv
// Directed bench for tdm_demux1to4: a framed (REQUIRE_SOF=1) and a free-running
// (REQUIRE_SOF=0) instance share one stimulus stream and are checked against beat-count models.
module tb_tdm_demux1to4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_sof = 1'b0;

    logic [7:0] a1, b1, c1, d1, a0, b0, c0, d0;
    logic       fv1, fv0, lk1, lk0, se1, se0;
    logic [1:0] sl1, sl0;

    tdm_demux1to4 #(.W(8), .REQUIRE_SOF(1'b1)) dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sof(din_sof),
        .a(a1), .b(b1), .c(c1), .d(d1), .frame_valid(fv1), .slot(sl1),
        .locked(lk1), .sync_err(se1));

    tdm_demux1to4 #(.W(8), .REQUIRE_SOF(1'b0)) dut0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sof(din_sof),
        .a(a0), .b(b0), .c(c0), .d(d0), .frame_valid(fv0), .slot(sl0),
        .locked(lk0), .sync_err(se0));

    always #5 clk = ~clk;

    int cmp_n = 0;
    int bad_n = 0;
    bit chk_en = 1'b0;
    int fv0_pulses = 0;

    // Model state per instance: index 0 = free-running, 1 = framed.
    logic [7:0] stage [2][4];
    logic [7:0] out_e [2][4];
    int         cnt [2];
    bit         hunt [2];
    bit         fv_e [2];
    bit         err_e [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 4; k++) begin
                out_e[m][k] = '0;
                stage[m][k] = '0;
            end
            cnt[m]   = 0;
            hunt[m]  = (m == 1);
            fv_e[m]  = 1'b0;
            err_e[m] = 1'b0;
        end
    endtask

    // cnt = beats of the current frame already accepted; a 4th completes it.
    task automatic model_step(input int m, input bit v, input bit s_in, input logic [7:0] dv);
        bit s;
        s = s_in && (m == 1);
        fv_e[m]  = 1'b0;
        err_e[m] = 1'b0;
        if (!v) return;
        if (hunt[m]) begin
            if (s) begin
                stage[m][0] = dv;
                cnt[m]      = 1;
                hunt[m]     = 1'b0;
            end
            return;
        end
        if (s) begin
            err_e[m]    = (cnt[m] != 0);
            stage[m][0] = dv;
            cnt[m]      = 1;
        end else if (cnt[m] == 0 && m == 1) begin
            err_e[m] = 1'b1;
            hunt[m]  = 1'b1;
        end else begin
            stage[m][cnt[m]] = dv;
            cnt[m]++;
            if (cnt[m] == 4) begin
                for (int k = 0; k < 4; k++) out_e[m][k] = stage[m][k];
                fv_e[m] = 1'b1;
                cnt[m]  = 0;
            end
        end
    endtask

    task automatic beat(input bit v, input bit s, input logic [7:0] dv);
        din_valid = v;
        din_sof   = s;
        din       = dv;
        @(posedge clk);
        model_step(1, v, s, dv);
        model_step(0, v, s, dv);
        #1;
        din_valid = 1'b0;
        din_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b1, 8'hEE);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m1.a", a1, out_e[1][0]);  chk("m1.b", b1, out_e[1][1]);
            chk("m1.c", c1, out_e[1][2]);  chk("m1.d", d1, out_e[1][3]);
            chk("m1.frame_valid", fv1, fv_e[1]);
            chk("m1.sync_err", se1, err_e[1]);
            chk("m1.locked", lk1, !hunt[1]);
            chk("m1.slot", sl1, hunt[1] ? 0 : cnt[1]);
            chk("m0.a", a0, out_e[0][0]);  chk("m0.b", b0, out_e[0][1]);
            chk("m0.c", c0, out_e[0][2]);  chk("m0.d", d0, out_e[0][3]);
            chk("m0.frame_valid", fv0, fv_e[0]);
            chk("m0.sync_err", se0, err_e[0]);
            chk("m0.locked", lk0, !hunt[0]);
            chk("m0.slot", sl0, hunt[0] ? 0 : cnt[0]);
            if (fv0) fv0_pulses++;
        end
    end

    task automatic sync_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.a", a1, 0);
        chk("reset.locked1", lk1, 0);
        chk("reset.locked0", lk0, 1);
        chk("reset.slot", sl1, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // 1: clean frame, valid every cycle
        beat(1, 1, 8'h11); beat(1, 0, 8'h22); beat(1, 0, 8'h33); beat(1, 0, 8'h44);
        chk("t1.fv", fv1, 1);
        chk("t1.abcd", {a1, b1, c1, d1}, 32'h11223344);
        idle(1);
        chk("t1.fv_once", fv1, 0);

        // 2: beats before lock are dropped
        sync_reset();
        beat(1, 0, 8'h55); beat(1, 0, 8'h66);
        chk("t2.hunting", lk1, 0);
        beat(1, 1, 8'h01); beat(1, 0, 8'h02); beat(1, 0, 8'h03); beat(1, 0, 8'h04);
        chk("t2.abcd", {a1, b1, c1, d1}, 32'h01020304);
        chk("t2.no_err", se1, 0);

        // 3: early marker restarts the frame
        beat(1, 1, 8'h11); beat(1, 0, 8'h22); beat(1, 1, 8'h77);
        chk("t3.err", se1, 1);
        beat(1, 0, 8'h88); beat(1, 0, 8'h99); beat(1, 0, 8'hAA);
        chk("t3.abcd", {a1, b1, c1, d1}, 32'h778899AA);

        // 4: missing marker after a complete frame
        beat(1, 0, 8'h5A);
        chk("t4.err", se1, 1);
        chk("t4.unlocked", lk1, 0);
        chk("t4.hold", {a1, b1, c1, d1}, 32'h778899AA);

        // 5: gapped frame interrupted by an asynchronous reset
        beat(1, 1, 8'h10); idle(2); beat(1, 0, 8'h20); idle(1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("t5.async_a", a1, 0);
        chk("t5.async_d0", d0, 0);
        chk("t5.async_locked", lk1, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        beat(1, 0, 8'h30); idle(3); beat(1, 0, 8'h40); idle(1);
        chk("t5.no_fv", fv1, 0);
        chk("t5.still_zero", a1, 0);
        beat(1, 1, 8'h50); idle(1); beat(1, 0, 8'h60); beat(1, 0, 8'h70); idle(2); beat(1, 0, 8'h80);
        chk("t5.abcd", {a1, b1, c1, d1}, 32'h50607080);

        // 6: free-running instance, no markers
        sync_reset();
        fv0_pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            beat(1, 0, 8'(i));
            if (i == 4) chk("t6.frame1", {a0, b0, c0, d0}, 32'h01020304);
        end
        chk("t6.frame2", {a0, b0, c0, d0}, 32'h05060708);
        idle(2);
        chk("t6.pulses", fv0_pulses, 2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end

endmodule
